// File: rtl/mcycle_ctrl.sv
// Multi-cycle MIPS-style control FSM: sequences fetch/decode/execute/memory/writeback,
// with bounded waits on memory and the mul/div unit and a single-cycle exception state.
module mcycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int MD_TIMEOUT  = 40,
    parameter bit BYTE_EN     = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    input  logic       overflow,
    input  logic       md_done,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       mem_read,
    output logic       mem_write,
    output logic       byte_sel,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       reg_write,
    output logic       md_start,
    output logic       epc_write,
    output logic [2:0] pc_src,
    output logic [1:0] reg_dst,
    output logic [2:0] mem_to_reg,
    output logic [2:0] alu_op,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] exc_cause,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_RESET, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_MEM_ADDR,
        S_MEM_RD, S_MEM_WR, S_WB_MEM, S_BRANCH, S_JUMP, S_JR, S_MULDIV, S_EXC
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100, OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010, OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_LW    = 6'b100011, OP_SW   = 6'b101011;
    localparam logic [5:0] OP_LB    = 6'b100000, OP_SB   = 6'b101000;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND  = 6'b100100;
    localparam logic [5:0] F_SLT = 6'b101010, F_JR  = 6'b001000;
    localparam logic [5:0] F_MULT = 6'b011000, F_DIV = 6'b011010;

    localparam int MAX_TO = (MEM_TIMEOUT > MD_TIMEOUT) ? MEM_TIMEOUT : MD_TIMEOUT;
    localparam int CNT_W  = $clog2(MAX_TO + 1);
    // The last allowed low cycle is TIMEOUT-1 counted from zero.
    localparam logic [CNT_W-1:0] MEM_LAST = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] MD_LAST  = CNT_W'(MD_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cause_q, cause_d;
    logic             wait_inc;
    logic             is_byte, is_load, is_store;

    assign is_byte  = BYTE_EN && ((opcode == OP_LB) || (opcode == OP_SB));
    assign is_load  = (opcode == OP_LW) || (BYTE_EN && (opcode == OP_LB));
    assign is_store = (opcode == OP_SW) || (BYTE_EN && (opcode == OP_SB));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cause_d       = cause_q;
        wait_inc      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        byte_sel      = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        md_start      = 1'b0;
        epc_write     = 1'b0;
        pc_src        = 3'b000;
        reg_dst       = 2'b00;
        mem_to_reg    = 3'b000;
        alu_op        = 3'b000;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;

        unique case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_b = 2'b01;
                    alu_op    = 3'b001;
                    state_d   = S_DECODE;
                end else if (cnt_q == MEM_LAST) begin
                    state_d = S_EXC;
                    cause_d = 2'b11;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = 3'b001;
                state_d   = S_EXC;
                cause_d   = 2'b01;
                if (opcode == OP_RTYPE) begin
                    if (funct == F_ADD || funct == F_SUB || funct == F_AND || funct == F_SLT)
                        state_d = S_EXEC_R;
                    else if (funct == F_JR)
                        state_d = S_JR;
                    else if (funct == F_MULT || funct == F_DIV)
                        state_d = S_MULDIV;
                end else if (opcode == OP_ADDI)
                    state_d = S_EXEC_I;
                else if (opcode == OP_BEQ || opcode == OP_BNE)
                    state_d = S_BRANCH;
                else if (opcode == OP_J || opcode == OP_JAL)
                    state_d = S_JUMP;
                else if (is_load || is_store)
                    state_d = S_MEM_ADDR;
                if (state_d != S_EXC)
                    cause_d = cause_q;
            end
            S_EXEC_R: begin
                alu_src_a = 2'b01;
                case (funct)
                    F_ADD:   alu_op = 3'b001;
                    F_SUB:   alu_op = 3'b010;
                    F_AND:   alu_op = 3'b011;
                    F_SLT:   alu_op = 3'b100;
                    default: alu_op = 3'b000;
                endcase
                if (overflow && (funct == F_ADD || funct == F_SUB)) begin
                    state_d = S_EXC;
                    cause_d = 2'b10;
                end else begin
                    state_d = S_WB_R;
                end
            end
            S_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 2'b01;
                state_d   = S_FETCH;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                alu_op    = 3'b001;
                if (overflow) begin
                    state_d = S_EXC;
                    cause_d = 2'b10;
                end else begin
                    state_d = S_WB_I;
                end
            end
            S_WB_I: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                alu_op    = 3'b001;
                state_d   = is_load ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD, S_MEM_WR: begin
                i_or_d    = 1'b1;
                mem_read  = (state_q == S_MEM_RD);
                mem_write = (state_q == S_MEM_WR);
                byte_sel  = is_byte;
                if (mem_ready) begin
                    state_d = (state_q == S_MEM_RD) ? S_WB_MEM : S_FETCH;
                end else if (cnt_q == MEM_LAST) begin
                    state_d = S_EXC;
                    cause_d = 2'b11;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 3'b001;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                pc_write_cond = 1'b1;
                alu_src_a     = 2'b01;
                alu_op        = 3'b010;
                pc_src        = 3'b001;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 3'b010;
                if (opcode == OP_JAL) begin
                    reg_write  = 1'b1;
                    reg_dst    = 2'b10;
                    mem_to_reg = 3'b011;
                end
                state_d = S_FETCH;
            end
            S_JR: begin
                pc_write = 1'b1;
                pc_src   = 3'b011;
                state_d  = S_FETCH;
            end
            S_MULDIV: begin
                // Counter is zero only in the first MULDIV cycle, since every later cycle follows a low md_done.
                md_start = (cnt_q == '0);
                if (md_done) begin
                    state_d = S_FETCH;
                end else if (cnt_q == MD_LAST) begin
                    state_d = S_EXC;
                    cause_d = 2'b11;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            S_EXC: begin
                epc_write = 1'b1;
                pc_write  = 1'b1;
                pc_src    = 3'b100;
                state_d   = S_FETCH;
            end
            default: state_d = S_RESET;
        endcase

        if (state_d == S_FETCH && state_q != S_FETCH)
            cause_d = 2'b00;
        cnt_d = (state_d != state_q) ? '0 : (wait_inc ? cnt_q + CNT_W'(1) : cnt_q);

        exc_cause = cause_q;
        state_o   = state_q;
        if (reset) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            byte_sel      = 1'b0;
            i_or_d        = 1'b0;
            ir_write      = 1'b0;
            reg_write     = 1'b0;
            md_start      = 1'b0;
            epc_write     = 1'b0;
            pc_src        = 3'b000;
            reg_dst       = 2'b00;
            mem_to_reg    = 3'b000;
            alu_op        = 3'b000;
            alu_src_a     = 2'b00;
            alu_src_b     = 2'b00;
            exc_cause     = 2'b00;
            state_o       = 4'd0;
        end
    end

endmodule
